// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of the VGA timing interface. Samples raw
// hsync/vsync/de, measures line and frame geometry and declares lock once
// the geometry repeats for LOCK_FRAMES consecutive frames.
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   hsync_in, vsync_in, de_in   raw sync / display-enable (polarity by parameter)
//   locked                      geometry stable, measurements valid
//   frame_start                 one-cycle pulse per vsync assertion
//   err                         one-cycle pulse on loss of lock or timeout
//   h_total/h_sync_w/h_active   line geometry in clocks
//   v_total/v_sync_w/v_active   frame geometry in lines
module vga_sync_rx #(
  parameter bit          HSYNC_ACTIVE_LOW = 1'b1,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b0,
  parameter bit          DE_ACTIVE_LOW    = 1'b0,
  parameter int unsigned LOCK_FRAMES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [11:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_w,
  output logic [10:0] v_active
);
  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned MW = 4;
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  typedef struct packed {
    logic [HW-1:0] h_total;
    logic [HW-1:0] h_sync_w;
    logic [HW-1:0] h_active;
    logic [VW-1:0] v_total;
    logic [VW-1:0] v_sync_w;
    logic [VW-1:0] v_active;
  } geom_t;

  // [0] polarity-normalised sample, [1] level acted on, [2] previous level
  logic [2:0] hs_sr, vs_sr, de_sr;
  logic       hs_lvl, vs_lvl, de_lvl;
  logic       hs_rise, vs_rise, de_rise;

  logic [HW-1:0] hcnt, hsw_cnt, dew_cnt, last_len, first_len, line_len;
  logic [VW-1:0] vcnt, vsw_cnt, vde_cnt;
  logic          first_valid, frame_bad, timeout;

  state_t        state;
  logic [MW-1:0] match_cnt;
  logic          ref_valid;
  geom_t         ref_set, meas, cap;
  logic          cap_bad;

  // Input stage: normalise polarity and delay for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], hsync_in ^ HSYNC_ACTIVE_LOW};
      vs_sr <= {vs_sr[1:0], vsync_in ^ VSYNC_ACTIVE_LOW};
      de_sr <= {de_sr[1:0], de_in ^ DE_ACTIVE_LOW};
    end
  end

  assign hs_lvl   = hs_sr[1];
  assign vs_lvl   = vs_sr[1];
  assign de_lvl   = de_sr[1];
  assign hs_rise  = hs_sr[1] & ~hs_sr[2];
  assign vs_rise  = vs_sr[1] & ~vs_sr[2];
  assign de_rise  = de_sr[1] & ~de_sr[2];
  assign line_len = hcnt + HW'(1);
  assign timeout  = (hcnt == H_MAX) || (vcnt == V_MAX);

  // Frame set as it stands at this frame close; a coincident line close
  // belongs to the frame being closed.
  always_comb begin
    cap          = '0;
    cap.h_total  = hs_rise ? line_len : last_len;
    cap.h_sync_w = hsw_cnt;
    cap.h_active = dew_cnt;
    cap.v_total  = (hs_rise && vcnt != V_MAX) ? vcnt + VW'(1) : vcnt;
    cap.v_sync_w = (hs_rise && vs_lvl && vsw_cnt != V_MAX) ? vsw_cnt + VW'(1) : vsw_cnt;
    cap.v_active = vde_cnt;
    cap_bad      = frame_bad | (hs_rise & first_valid & (line_len != first_len));
  end

  // Line / frame measurement counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      hsw_cnt     <= '0;
      dew_cnt     <= '0;
      last_len    <= '0;
      first_len   <= '0;
      first_valid <= 1'b0;
      frame_bad   <= 1'b0;
      vcnt        <= '0;
      vsw_cnt     <= '0;
      vde_cnt     <= '0;
    end else begin
      if (hs_rise) begin
        hcnt     <= '0;
        last_len <= line_len;
      end else if (hcnt != H_MAX) begin
        hcnt <= hcnt + HW'(1);
      end

      if (hs_rise)                          hsw_cnt <= HW'(1);
      else if (hs_lvl && hsw_cnt != H_MAX)  hsw_cnt <= hsw_cnt + HW'(1);

      if (de_rise)                          dew_cnt <= HW'(1);
      else if (de_lvl && dew_cnt != H_MAX)  dew_cnt <= dew_cnt + HW'(1);

      if (vs_rise) begin
        vcnt        <= '0;
        vsw_cnt     <= '0;
        vde_cnt     <= de_rise ? VW'(1) : VW'(0);
        first_valid <= 1'b0;
        frame_bad   <= 1'b0;
      end else begin
        if (hs_rise && vcnt != V_MAX)             vcnt    <= vcnt + VW'(1);
        if (hs_rise && vs_lvl && vsw_cnt != V_MAX) vsw_cnt <= vsw_cnt + VW'(1);
        if (de_rise && vde_cnt != V_MAX)          vde_cnt <= vde_cnt + VW'(1);
        if (hs_rise) begin
          if (!first_valid) begin
            first_len   <= line_len;
            first_valid <= 1'b1;
          end else if (line_len != first_len) begin
            frame_bad <= 1'b1;
          end
        end
      end
    end
  end

  // Lock FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      match_cnt   <= '0;
      ref_valid   <= 1'b0;
      ref_set     <= '0;
      meas        <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      err         <= 1'b0;
      frame_start <= vs_rise;
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (!timeout && vs_rise) begin
            state     <= VERIFY;
            match_cnt <= '0;
            ref_valid <= 1'b0;
          end
        end
        VERIFY: begin
          if (vs_rise) begin
            meas      <= cap;
            ref_set   <= cap;
            ref_valid <= 1'b1;
          end
          if (timeout) begin
            state <= SEARCH;
          end else if (vs_rise && ref_valid) begin
            if (cap == ref_set && !cap_bad) begin
              match_cnt <= match_cnt + MW'(1);
              if ((match_cnt + MW'(1)) >= MW'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (vs_rise) meas <= cap;
          if (timeout || (hs_rise && line_len != meas.h_total) ||
              (vs_rise && (cap != meas || cap_bad))) begin
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= SEARCH;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign h_total  = meas.h_total;
  assign h_sync_w = meas.h_sync_w;
  assign h_active = meas.h_active;
  assign v_total  = meas.v_total;
  assign v_sync_w = meas.v_sync_w;
  assign v_active = meas.v_active;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx: a small raster generator drives two
// instances (default polarities and swapped h/v polarities) and the
// outputs are checked against hand-computed geometry and lock timing.
module tb_vga_sync_rx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Active-high raster levels
  logic hs_a = 1'b0, vs_a = 1'b0, de_a = 1'b0;

  logic        locked0, frame_start0, err0, locked1, frame_start1, err1;
  logic [11:0] h_total0, h_sync_w0, h_active0, h_total1, h_sync_w1, h_active1;
  logic [10:0] v_total0, v_sync_w0, v_active0, v_total1, v_sync_w1, v_active1;

  vga_sync_rx u_dut0 (
    .clk(clk), .rst(rst), .hsync_in(~hs_a), .vsync_in(vs_a), .de_in(de_a),
    .locked(locked0), .frame_start(frame_start0), .err(err0),
    .h_total(h_total0), .h_sync_w(h_sync_w0), .h_active(h_active0),
    .v_total(v_total0), .v_sync_w(v_sync_w0), .v_active(v_active0));

  vga_sync_rx #(.HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .hsync_in(hs_a), .vsync_in(~vs_a), .de_in(de_a),
    .locked(locked1), .frame_start(frame_start1), .err(err1),
    .h_total(h_total1), .h_sync_w(h_sync_w1), .h_active(h_active1),
    .v_total(v_total1), .v_sync_w(v_sync_w1), .v_active(v_active1));

  int checks = 0, errors = 0;
  int htot, hs_beg, hs_len, hact, vtot, vs_beg, vs_len, vact;
  int h = 0, v = 0, short_line = 0;
  bit stuck = 0, short_pend = 0;
  bit ev_vs, ev_hs;
  int ev_line;
  int tick_no = 0, last_hs_tick = 0, err_tick = 0;
  int fs_cnt0 = 0, err_cnt0 = 0, err_base = 0;
  bit found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input int ht, hb, hl, ha, vt, vb, vl, va);
    htot = ht; hs_beg = hb; hs_len = hl; hact = ha;
    vtot = vt; vs_beg = vb; vs_len = vl; vact = va;
    h = 0; v = 0;
  endtask

  // Drive one pixel, let it be sampled at the next edge, step the raster
  task automatic tick();
    logic hs_n, vs_n, de_n;
    int   cur_htot;
    if (stuck) begin
      hs_n = 1'b0; vs_n = 1'b0; de_n = 1'b0;
    end else begin
      hs_n = (h >= hs_beg) && (h < hs_beg + hs_len);
      vs_n = (v >= vs_beg) && (v < vs_beg + vs_len);
      de_n = (h < hact) && (v < vact);
    end
    ev_hs   = hs_n && !hs_a;
    ev_vs   = vs_n && !vs_a;
    ev_line = v;
    hs_a = hs_n; vs_a = vs_n; de_a = de_n;
    @(posedge clk);
    #1;
    tick_no++;
    if (ev_hs) last_hs_tick = tick_no;
    if (frame_start0) fs_cnt0++;
    if (err0) err_cnt0++;
    cur_htot = (short_pend && v == short_line) ? htot - 1 : htot;
    if (h >= cur_htot - 1) begin
      if (short_pend && v == short_line) short_pend = 0;
      h = 0;
      v = (v == vtot - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
  endtask

  task automatic run_until_vs(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      tick();
      seen = ev_vs;
    end
    chk(tag, seen, 1);
  endtask

  task automatic run_until_hs_line(input int line, input string tag);
    bit seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      tick();
      seen = ev_hs && (ev_line == line);
    end
    chk(tag, seen, 1);
  endtask

  task automatic chk_geom(input int ht, hsw, ha, vt, vsw, va);
    chk("h_total0", h_total0, ht);   chk("h_total1", h_total1, ht);
    chk("h_sync_w0", h_sync_w0, hsw); chk("h_sync_w1", h_sync_w1, hsw);
    chk("h_active0", h_active0, ha); chk("h_active1", h_active1, ha);
    chk("v_total0", v_total0, vt);   chk("v_total1", v_total1, vt);
    chk("v_sync_w0", v_sync_w0, vsw); chk("v_sync_w1", v_sync_w1, vsw);
    chk("v_active0", v_active0, va); chk("v_active1", v_active1, va);
  endtask

  // Lock sequence: three assertions leave it unlocked, the fourth locks at N+2
  task automatic relock(input string tag);
    for (int k = 0; k < 3; k++) run_until_vs({tag, "_vs"});
    tick(); tick();
    chk({tag, "_early"}, locked0, 0);
    run_until_vs({tag, "_vs4"});
    tick();
    chk({tag, "_n1"}, locked0, 0);
    tick();
    chk({tag, "_locked0"}, locked0, 1);
    chk({tag, "_locked1"}, locked1, 1);
  endtask

  initial begin
    rst = 1'b1;
    set_mode(40, 30, 4, 24, 12, 9, 2, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked0", locked0, 0);
    chk("rst_frame_start0", frame_start0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_h_total0", h_total0, 0);
    chk("rst_v_active0", v_active0, 0);
    chk("rst_locked1", locked1, 0);
    rst = 1'b0;

    // Initial lock on the reference raster
    relock("lock");
    chk("lock_fs0", frame_start0, 1);
    chk("lock_fs1", frame_start1, 1);
    chk("fs_count", fs_cnt0, 4);
    chk_geom(40, 4, 24, 12, 2, 8);

    // One 39-clock line: err on the hs assertion that closes it
    err_base   = err_cnt0;
    short_line = 3;
    short_pend = 1;
    run_until_hs_line(4, "short_hs");
    tick();
    chk("short_err_n1", err0, 0);
    tick();
    chk("short_err0", err0, 1);
    chk("short_err1", err1, 1);
    chk("short_unlock", locked0, 0);
    tick();
    chk("short_err_pulse", err0, 0);
    relock("short_relock");
    chk("short_err_count", err_cnt0 - err_base, 1);

    // Sync lines stuck inactive: hcnt saturation timeout
    stuck = 1;
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick();
      if (err0) begin
        found    = 1;
        err_tick = tick_no;
      end
    end
    chk("timeout_seen", found, 1);
    chk("timeout_delay", err_tick - last_hs_tick, 4098);
    chk("timeout_err1", err1, 1);
    chk("timeout_unlock", locked0, 0);
    chk_geom(40, 4, 24, 12, 2, 8);

    // Resume, lock, then reset mid-frame
    stuck = 0;
    set_mode(40, 30, 4, 24, 12, 9, 2, 8);
    relock("resume");
    run_until_hs_line(3, "rst_hs");
    rst = 1'b1;
    tick();
    chk("midrst_locked0", locked0, 0);
    chk("midrst_locked1", locked1, 0);
    chk("midrst_fs0", frame_start0, 0);
    chk("midrst_err0", err0, 0);
    chk_geom(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    relock("rst_relock");
    chk_geom(40, 4, 24, 12, 2, 8);

    // Mode change to a 30x10 raster
    err_base = err_cnt0;
    set_mode(30, 24, 3, 20, 10, 8, 1, 6);
    relock("mode");
    chk("mode_err_count", err_cnt0 - err_base, 1);
    chk_geom(30, 3, 20, 10, 1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
